// File: rtl/fifo_wr_arbiter.sv
// Four-requester round-robin write arbiter feeding one shared FIFO.
// A grant holds for up to BURST_MAX beats; bursts are separated by one arbitration cycle.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [3:0]          req_valid,
    input  logic [4*DATA_W-1:0] req_data,
    output logic [3:0]          req_ready,
    input  logic                fifo_full,
    input  logic                fifo_alm_full,
    output logic                fifo_wren,
    output logic [DATA_W-1:0]   fifo_wrdata,
    output logic [1:0]          grant_id,
    output logic                busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_g;
    logic [3:0]  r_cnt;
    logic [1:0]  w_rr_ptr_nxt;
    logic [1:0]  w_g_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    logic        w_found;
    logic        w_xfer;
    logic        w_last;
    logic        w_exit;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_xfer = (r_state == BURST) && req_valid[r_g] && !fifo_full;
    assign w_last = (({1'b0, r_cnt} + 5'd1) == 5'(BURST_MAX)) || fifo_alm_full;
    assign w_exit = (r_state == BURST) && ((w_xfer && w_last) || !req_valid[r_g]);

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_g_nxt      = r_g;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_g_nxt     = w_sel;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
                if (w_exit) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = r_g + 2'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state  <= IDLE;
            r_rr_ptr <= 2'd0;
            r_g      <= 2'd0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_g      <= w_g_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Reset (active high) blocks the write in the very cycle it is asserted.
    assign fifo_wren   = w_xfer && !rstn;
    assign req_ready   = (r_state == BURST && !fifo_full && !rstn) ? (4'b0001 << r_g) : 4'b0000;
    assign fifo_wrdata = req_data[r_g*DATA_W +: DATA_W];
    assign grant_id    = r_g;
    assign busy        = (r_state == BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of write data, matching the shared FIFO.
REQ-002 Parameter BURST_MAX, default 4, legal 1..15: maximum beats per grant.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-high (asserted = 1) despite the name.
REQ-005 req_valid  input  4  per-requester beat-valid, bit i = requester i.
REQ-006 req_data  input  4*DATA_W  per-requester data, slice i = bits [i*DATA_W +: DATA_W].
REQ-007 req_ready  output  4  per-requester accept; at most one bit set per cycle.
REQ-008 fifo_full  input  1  FIFO full flag (o_full).
REQ-009 fifo_alm_full  input  1  FIFO almost-full flag (o_alm_full).
REQ-010 fifo_wren  output  1  FIFO write enable (drives i_wren).
REQ-011 fifo_wrdata  output  DATA_W  FIFO write data (drives i_wrdata).
REQ-012 grant_id  output  2  index of the current owner; registered.
REQ-013 busy  output  1  1 while in state BURST.

Function
REQ-014 The block SHALL use a two-state FSM, IDLE and BURST, plus a 2-bit round-robin pointer rr_ptr, a 2-bit grant register g, and a 4-bit beat counter.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL select the first set bit searching rr_ptr, rr_ptr+1, ... modulo 4, load g, clear the beat counter, and enter BURST next cycle; otherwise it stays in IDLE.
REQ-016 In IDLE, req_ready and fifo_wren SHALL be 0, giving one arbitration cycle between bursts.
REQ-017 BURST transfer condition: xfer = req_valid[g] & ~fifo_full.
REQ-018 fifo_wren SHALL equal xfer combinationally, fifo_wrdata SHALL equal req_data slice g, and req_ready SHALL be one-hot on bit g with value ~fifo_full; all other ready bits are 0.
REQ-019 Each xfer cycle SHALL increment the beat counter by 1.
REQ-020 BURST exit to IDLE SHALL occur at the next edge when any of these holds: xfer with counter+1 == BURST_MAX; xfer with fifo_alm_full = 1 (truncation after the current beat); req_valid[g] = 0 (requester withdrew).
REQ-021 On every BURST exit, rr_ptr SHALL load g+1 modulo 4.
REQ-022 fifo_full = 1 in BURST with req_valid[g] = 1 SHALL stall: no write, counter held, state and grant held.
REQ-023 A requester whose valid bit falls in IDLE before selection SHALL simply not be selected; no partial grant.
REQ-024 grant_id SHALL equal g at all times, and busy SHALL equal (state == BURST).
REQ-025 No requester SHALL wait more than 3 bursts while its valid bit is held high.

Reset
REQ-026 With rstn = 1 at a rising edge, the block SHALL go to IDLE with rr_ptr = 0, g = 0, and counter = 0, regardless of state or an in-progress burst.
REQ-027 Outputs after reset: req_ready = 0, fifo_wren = 0, grant_id = 0, busy = 0, and fifo_wrdata = req_data slice 0.
REQ-028 Reset asserted mid-burst SHALL drop the burst with no further write in the reset cycle or after it, and SHALL NOT move rr_ptr to g+1.

Verification
REQ-029 Single requester: valid[2] held, 10 beats, BURST_MAX = 4, FIFO never full -> writes in bursts of 4, 4, 2 with one idle cycle between bursts; grant_id = 2 throughout.
REQ-030 All four valid after reset -> grant order 0, 1, 2, 3, 0, each burst of 4 beats; data on fifo_wrdata matches the granted slice in order.
REQ-031 fifo_full pulsed 3 cycles mid-burst -> fifo_wren = 0 and req_ready = 0 for those 3 cycles, counter frozen, and the burst still totals 4 beats.
REQ-032 fifo_alm_full rises during beat 2 of a burst -> the burst ends after beat 2; the next grant goes to the next requester.
REQ-033 Requester 1 drops valid after 1 beat -> IDLE next cycle, rr_ptr = 2; if requesters 0 and 3 are valid, requester 3 is granted.
REQ-034 rstn asserted during beat 3 of requester 2's burst -> no write in that cycle; after release with all requesters valid, requester 0 is granted first.
